// File: rtl/updown_counter_pkg.sv
// Shared types and defaults for the up/down counter.
// Latency: n/a (declarations only).
// Backpressure: n/a.
package updown_counter_pkg;

  // Default counter width in bits.
  localparam int WIDTH_DEFAULT = 8;

  // RUN counts normally; HALT freezes the counter after a one-shot terminal step.
  typedef enum logic {
    RUN  = 1'b0,
    HALT = 1'b1
  } state_t;

endpackage

// File: rtl/updown_counter_if.sv
// Control/status bundle between a counter user (master) and the counter (slave).
// Latency: n/a (wiring only).
// Backpressure: none; the counter accepts control every cycle.
interface updown_counter_if
  import updown_counter_pkg::*;
#(
  parameter int WIDTH = WIDTH_DEFAULT
) ();

  logic             en;
  logic             up;
  logic             oneshot;
  logic             load;
  logic [WIDTH-1:0] load_val;
  logic [WIDTH-1:0] limit;
  logic [WIDTH-1:0] q;
  logic             tc;
  logic             done;

  // Driver of the controls, observer of the count.
  modport master (
    output en, up, oneshot, load, load_val, limit,
    input  q, tc, done
  );

  // The counter itself.
  modport slave (
    input  en, up, oneshot, load, load_val, limit,
    output q, tc, done
  );

endinterface

// File: rtl/updown_counter.sv
// Up/down counter over 0..limit with wrap or one-shot stop, load and sync reset.
// Latency: q/tc/done update one cycle after the edge that samples the controls.
// Backpressure: none; en=0 or HALT simply holds the count.
module updown_counter
  import updown_counter_pkg::*;
#(
  parameter int          WIDTH     = WIDTH_DEFAULT,
  parameter int unsigned RESET_VAL = 0
) (
  input  logic                clk,
  input  logic                reset,
  updown_counter_if.slave     bus
);

  localparam logic [WIDTH-1:0] ONE    = {{(WIDTH-1){1'b0}}, 1'b1};
  localparam logic [WIDTH-1:0] ZERO   = '0;
  localparam logic [WIDTH-1:0] RST_Q  = WIDTH'(RESET_VAL);

  logic [WIDTH-1:0] r_q;
  logic             r_tc;
  logic             r_done;
  state_t           r_state;

  logic [WIDTH-1:0] w_q_nxt;
  logic             w_tc_nxt;
  logic             w_done_nxt;
  state_t           w_state_nxt;
  logic             w_terminal;

  // Terminal detection: >= on the way up so an over-range load still wraps/stops.
  assign w_terminal = bus.up ? (r_q >= bus.limit) : (r_q == ZERO);

  // Next-state selection in priority load > count > hold; tc is a one-cycle pulse.
  always_comb begin
    w_q_nxt     = r_q;
    w_tc_nxt    = 1'b0;
    w_done_nxt  = r_done;
    w_state_nxt = r_state;
    if (bus.load) begin
      w_q_nxt     = bus.load_val;
      w_done_nxt  = 1'b0;
      w_state_nxt = RUN;
    end else if (bus.en && (r_state == RUN)) begin
      if (w_terminal) begin
        w_tc_nxt = 1'b1;
        if (bus.oneshot) begin
          w_done_nxt  = 1'b1;
          w_state_nxt = HALT;
        end else begin
          w_q_nxt = bus.up ? ZERO : bus.limit;
        end
      end else begin
        w_q_nxt = bus.up ? (r_q + ONE) : (r_q - ONE);
      end
    end
  end

  // State registers with synchronous active-high reset overriding everything.
  always_ff @(posedge clk) begin
    if (reset) begin
      r_q     <= RST_Q;
      r_tc    <= 1'b0;
      r_done  <= 1'b0;
      r_state <= RUN;
    end else begin
      r_q     <= w_q_nxt;
      r_tc    <= w_tc_nxt;
      r_done  <= w_done_nxt;
      r_state <= w_state_nxt;
    end
  end

  assign bus.q    = r_q;
  assign bus.tc   = r_tc;
  assign bus.done = r_done;

endmodule

// File: doc/updown_counter.md
UPDOWN_COUNTER -- requirements
Module: updown_counter

Interface
REQ-001 Parameter WIDTH, default 8: counter width in bits, legal range 2..32.
REQ-002 Parameter RESET_VAL, default 0: value of q after reset; must fit in WIDTH bits.
REQ-003 clk  input  1: single clock; all state changes on the rising edge.
REQ-004 reset  input  1: synchronous, active-high reset.
REQ-005 en  input  1: count enable; one step per cycle while high.
REQ-006 up  input  1: direction, 1 = increment, 0 = decrement.
REQ-007 oneshot  input  1: mode, 0 = free-run (wrap), 1 = one-shot (stop at terminal).
REQ-008 load  input  1: synchronous load strobe.
REQ-009 load_val  input  WIDTH: value loaded into q when load is high.
REQ-010 limit  input  WIDTH: upper count bound; count range is 0..limit inclusive.
REQ-011 q  output  WIDTH: registered count value.
REQ-012 tc  output  1: registered terminal-count pulse.
REQ-013 done  output  1: registered one-shot-complete flag.

Function
REQ-014 Priority order, evaluated each rising edge: reset > load > count > hold.
REQ-015 Load: q <= load_val; state <= RUN; done <= 0; tc <= 0; this holds regardless of en or state.
REQ-016 Hold: q, state and done keep their values when en=0 or state=HALT, and tc <= 0.
REQ-017 Up-terminal condition: up=1 and q >= limit. The >= comparison also covers a q loaded above limit.
REQ-018 Down-terminal condition: up=0 and q == 0.
REQ-019 Non-terminal count step: q <= q+1 (up) or q-1 (down); tc <= 0.
REQ-020 Terminal step, free-run: q <= 0 (up) or q <= limit (down); tc <= 1 for exactly the following cycle.
REQ-021 Terminal step, one-shot: q is unchanged; state <= HALT; done <= 1; tc <= 1 for one cycle.
REQ-022 State machine RUN/HALT: RUN -> HALT on a one-shot terminal step; HALT -> RUN only on load or reset.
REQ-023 While in HALT, done stays high and en/up/limit changes have no effect.
REQ-024 limit and oneshot are sampled every cycle; a change takes effect at the next edge with no pipelining.
REQ-025 Count latency: q reflects an enabled step one cycle after the edge at which en was sampled high.
REQ-026 limit=0: up-count stays at 0 with tc high every enabled cycle (free-run); down behaves identically.
REQ-027 Arithmetic is modulo 2^WIDTH. No carry or overflow beyond WIDTH bits is observable at any output.

Reset
REQ-028 When reset is high at an edge: q <= RESET_VAL, tc <= 0, done <= 0, state <= RUN.
REQ-029 Reset applied during any operation, including HALT or a concurrent load, aborts it; load_val is discarded.
REQ-030 The first count step occurs at the first edge with reset low and en high.

Structure
REQ-031 Shared package updown_counter_pkg holds the state typedef (RUN, HALT) and the WIDTH default constant.
REQ-032 Single flat module with no sub-modules; next-state logic in one combinational block, registers in one clocked block.

Verification
REQ-033 Baseline: reset 3 cycles, limit=255, up=1, en=1, oneshot=0, 200 cycles -> q displays 0..199, tc never high.
REQ-034 Wrap: limit=9, up count from 0 -> q 0..9,0,1; tc high only in the cycle where q=0 after wrap.
REQ-035 Down: load 2, limit=5, up=0 -> q 2,1,0,5,4; tc high the cycle q=5.
REQ-036 One-shot: limit=3, oneshot=1, from 0 -> q 0,1,2,3,3,3; done=1 from the cycle after q reaches 3; one tc pulse; load 0 -> q=0, done=0, counting resumes.
REQ-037 Collisions: load=1 with load_val=7 and en=1 -> q=7 with no increment; reset=1 with load=1 -> q=RESET_VAL.
REQ-038 Out-of-range load: load 12, limit=9, up -> next enabled step q=0 with a tc pulse; en=0 for 5 cycles -> q unchanged throughout.
